// File: rtl/svga_timing_receiver_pkg.sv
// Shared SVGA geometry constants, receiver FSM encoding and default counter widths.
// Expected geometry is used by the optional mode check (SVGA_TIMING_CHECK_EN).
package svga_timing_receiver_pkg;

  localparam int unsigned H_W_DEF  = 11;
  localparam int unsigned V_W_DEF  = 10;
  localparam int unsigned MATCH_W  = 4;

  // 800x600 reference raster
  localparam int unsigned H_TOTAL  = 1056;
  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_TOTAL  = 628;
  localparam int unsigned V_ACTIVE = 600;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/svga_timing_receiver_edge.sv
// Two-stage input capture with single-cycle rise/fall pulses taken from the captured pair.
module svga_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_d1;
  logic r_d2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_d1 <= 1'b0;
      r_d2 <= 1'b0;
    end else begin
      r_d1 <= i_sig;
      r_d2 <= r_d1;
    end
  end

  assign o_rise_c = r_d1 & ~r_d2;
  assign o_fall_c = ~r_d1 & r_d2;

endmodule

// File: rtl/svga_timing_receiver.sv
// Recovers raster coordinates from h_synch/v_synch/blank, measures frame geometry and tracks lock.
// Optional mode check against the reference raster is enabled by defining SVGA_TIMING_CHECK_EN.
module svga_timing_receiver
  import svga_timing_receiver_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned H_W         = H_W_DEF,
  parameter int unsigned V_W         = V_W_DEF
) (
  input  logic           pixel_clock,
  input  logic           reset,
  input  logic           h_synch_in,
  input  logic           v_synch_in,
  input  logic           blank_in,
  output logic           active,
  output logic [H_W-1:0] pixel_x,
  output logic [V_W-1:0] line_y,
  output logic           line_start,
  output logic           frame_start,
  output logic [H_W-1:0] h_total_meas,
  output logic [H_W-1:0] h_active_meas,
  output logic [V_W-1:0] v_total_meas,
  output logic [V_W-1:0] v_active_meas,
  output logic           locked,
  output logic           mode_error
);

  localparam logic [H_W-1:0]     H_MAX  = '1;
  localparam logic [V_W-1:0]     V_MAX  = '1;
  localparam logic [MATCH_W-1:0] LOCK_N = MATCH_W'(LOCK_FRAMES);

  logic w_h_rise, w_h_fall_unused;
  logic w_v_rise, w_v_fall_unused;
  logic w_b_rise, w_b_fall;

  svga_edge_detect u_h_edge (
    .i_clk(pixel_clock), .i_reset(reset), .i_sig(h_synch_in),
    .o_rise_c(w_h_rise), .o_fall_c(w_h_fall_unused)
  );

  svga_edge_detect u_v_edge (
    .i_clk(pixel_clock), .i_reset(reset), .i_sig(v_synch_in),
    .o_rise_c(w_v_rise), .o_fall_c(w_v_fall_unused)
  );

  svga_edge_detect u_b_edge (
    .i_clk(pixel_clock), .i_reset(reset), .i_sig(blank_in),
    .o_rise_c(w_b_rise), .o_fall_c(w_b_fall)
  );

  logic               r_active;
  logic [H_W-1:0]     r_pixel_x;
  logic [V_W-1:0]     r_line_y;
  logic               r_line_start;
  logic               r_frame_start;
  logic               r_new_frame;
  logic [H_W-1:0]     r_hcnt;
  logic [H_W-1:0]     r_h_len;
  logic [H_W-1:0]     r_hact_last;
  logic [V_W-1:0]     r_vcnt;
  logic [V_W-1:0]     r_vact;
  logic [H_W-1:0]     r_h_total_meas;
  logic [H_W-1:0]     r_h_active_meas;
  logic [V_W-1:0]     r_v_total_meas;
  logic [V_W-1:0]     r_v_active_meas;
  logic [MATCH_W-1:0] r_match_cnt;
  logic               r_locked;
  rx_state_e          r_state;

  logic [H_W-1:0]     w_px_inc;
  logic [H_W-1:0]     w_hcnt_inc;
  logic [V_W-1:0]     w_vcnt_inc;
  logic               w_timeout;
  logic [H_W-1:0]     w_cand_ht;
  logic [H_W-1:0]     w_cand_ha;
  logic [V_W-1:0]     w_cand_vt;
  logic [V_W-1:0]     w_cand_va;
  logic               w_cand_eq;
  logic [H_W-1:0]     w_ht_nxt;
  logic [H_W-1:0]     w_ha_nxt;
  logic [V_W-1:0]     w_vt_nxt;
  logic [V_W-1:0]     w_va_nxt;
  rx_state_e          w_state_nxt;
  logic               w_latch;
  logic [MATCH_W-1:0] w_match_nxt;
  logic               w_locked_nxt;

  assign w_px_inc   = (r_pixel_x == H_MAX) ? H_MAX : H_W'(r_pixel_x + 1'b1);
  assign w_hcnt_inc = (r_hcnt == H_MAX) ? H_MAX : H_W'(r_hcnt + 1'b1);
  assign w_vcnt_inc = (r_vcnt == V_MAX) ? V_MAX : V_W'(r_vcnt + 1'b1);
  assign w_timeout  = (r_hcnt == H_MAX);

  // Raster position recovery, two cycles behind blank_in
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_active      <= 1'b0;
      r_pixel_x     <= '0;
      r_line_y      <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_new_frame   <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_v_rise) begin
        r_new_frame <= 1'b1;
      end
      if (w_b_fall) begin
        r_active     <= 1'b1;
        r_pixel_x    <= '0;
        r_line_start <= 1'b1;
        if (r_new_frame || w_v_rise) begin
          r_line_y      <= '0;
          r_frame_start <= 1'b1;
          r_new_frame   <= 1'b0;
        end else begin
          r_line_y <= V_W'(r_line_y + 1'b1);
        end
      end else if (w_b_rise) begin
        r_active <= 1'b0;
      end else if (r_active) begin
        r_pixel_x <= w_px_inc;
      end
      if (w_timeout) begin
        r_active <= 1'b0;
      end
    end
  end

  // Running line/frame counters; r_hcnt counts cycles since the last h_synch rise
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_hcnt      <= '0;
      r_h_len     <= '0;
      r_hact_last <= '0;
      r_vcnt      <= '0;
      r_vact      <= '0;
    end else begin
      if (w_h_rise) begin
        r_hcnt  <= '0;
        r_h_len <= w_hcnt_inc;
      end else begin
        r_hcnt <= w_hcnt_inc;
      end
      if (w_b_rise && r_active) begin
        r_hact_last <= w_px_inc;
      end
      if (w_v_rise) begin
        r_vcnt <= '0;
        r_vact <= w_b_fall ? V_W'(1) : '0;
      end else begin
        if (w_h_rise) begin
          r_vcnt <= w_vcnt_inc;
        end
        if (w_b_fall) begin
          r_vact <= (r_vact == V_MAX) ? V_MAX : V_W'(r_vact + 1'b1);
        end
      end
    end
  end

  // A coincident h_synch rise still belongs to the frame that is ending
  assign w_cand_ht = w_h_rise ? w_hcnt_inc : r_h_len;
  assign w_cand_ha = r_hact_last;
  assign w_cand_vt = w_h_rise ? w_vcnt_inc : r_vcnt;
  assign w_cand_va = r_vact;
  assign w_cand_eq = (w_cand_ht == r_h_total_meas) && (w_cand_ha == r_h_active_meas) &&
                     (w_cand_vt == r_v_total_meas) && (w_cand_va == r_v_active_meas);

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_ACQUIRE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock tracking: one decision per v_synch rise, timeout overrides everything
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_match_nxt  = r_match_cnt;
    w_locked_nxt = r_locked;
    if (w_timeout) begin
      w_state_nxt  = ST_ACQUIRE;
      w_locked_nxt = 1'b0;
      w_match_nxt  = '0;
    end else if (w_v_rise) begin
      case (r_state)
        ST_ACQUIRE: w_state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          w_latch     = 1'b1;
          w_match_nxt = MATCH_W'(1);
          if (LOCK_N <= MATCH_W'(1)) begin
            w_state_nxt  = ST_LOCKED;
            w_locked_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (w_cand_eq) begin
            w_match_nxt = MATCH_W'(r_match_cnt + 1'b1);
            if (w_match_nxt >= LOCK_N) begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_latch     = 1'b1;
            w_match_nxt = MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!w_cand_eq) begin
            w_latch      = 1'b1;
            w_match_nxt  = MATCH_W'(1);
            w_locked_nxt = 1'b0;
            w_state_nxt  = ST_CONFIRM;
          end
        end
        default: w_state_nxt = ST_ACQUIRE;
      endcase
    end
  end

  assign w_ht_nxt = w_latch ? w_cand_ht : r_h_total_meas;
  assign w_ha_nxt = w_latch ? w_cand_ha : r_h_active_meas;
  assign w_vt_nxt = w_latch ? w_cand_vt : r_v_total_meas;
  assign w_va_nxt = w_latch ? w_cand_va : r_v_active_meas;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_match_cnt     <= '0;
      r_locked        <= 1'b0;
      r_h_total_meas  <= '0;
      r_h_active_meas <= '0;
      r_v_total_meas  <= '0;
      r_v_active_meas <= '0;
    end else begin
      r_match_cnt     <= w_match_nxt;
      r_locked        <= w_locked_nxt;
      r_h_total_meas  <= w_ht_nxt;
      r_h_active_meas <= w_ha_nxt;
      r_v_total_meas  <= w_vt_nxt;
      r_v_active_meas <= w_va_nxt;
    end
  end

`ifdef SVGA_TIMING_CHECK_EN
  logic r_mode_error;

  // Flag a locked raster that is not the reference mode
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_mode_error <= 1'b0;
    end else begin
      r_mode_error <= w_locked_nxt &&
                      ((w_ht_nxt != H_W'(H_TOTAL)) || (w_ha_nxt != H_W'(H_ACTIVE)) ||
                       (w_vt_nxt != V_W'(V_TOTAL)) || (w_va_nxt != V_W'(V_ACTIVE)));
    end
  end

  assign mode_error = r_mode_error;
`else
  assign mode_error = 1'b0;
`endif

  assign active        = r_active;
  assign pixel_x       = r_pixel_x;
  assign line_y        = r_line_y;
  assign line_start    = r_line_start;
  assign frame_start   = r_frame_start;
  assign h_total_meas  = r_h_total_meas;
  assign h_active_meas = r_h_active_meas;
  assign v_total_meas  = r_v_total_meas;
  assign v_active_meas = r_v_active_meas;
  assign locked        = r_locked;

endmodule

// File: tb/tb_svga_timing_receiver.sv
// Directed bench for svga_timing_receiver using scaled-down rasters and a due-cycle scoreboard.
// Mode-check expectations follow SVGA_TIMING_CHECK_EN.
module tb_svga_timing_receiver;

  localparam int unsigned H_W = 11;
  localparam int unsigned V_W = 10;
`ifdef SVGA_TIMING_CHECK_EN
  localparam int MERR_EN = 1;
`else
  localparam int MERR_EN = 0;
`endif

  logic           pixel_clock = 1'b0;
  logic           reset;
  logic           h_synch_in;
  logic           v_synch_in;
  logic           blank_in;
  logic           active;
  logic [H_W-1:0] pixel_x;
  logic [V_W-1:0] line_y;
  logic           line_start;
  logic           frame_start;
  logic [H_W-1:0] h_total_meas;
  logic [H_W-1:0] h_active_meas;
  logic [V_W-1:0] v_total_meas;
  logic [V_W-1:0] v_active_meas;
  logic           locked;
  logic           mode_error;

  svga_timing_receiver #(.LOCK_FRAMES(2), .H_W(H_W), .V_W(V_W)) dut (
    .pixel_clock(pixel_clock), .reset(reset),
    .h_synch_in(h_synch_in), .v_synch_in(v_synch_in), .blank_in(blank_in),
    .active(active), .pixel_x(pixel_x), .line_y(line_y),
    .line_start(line_start), .frame_start(frame_start),
    .h_total_meas(h_total_meas), .h_active_meas(h_active_meas),
    .v_total_meas(v_total_meas), .v_active_meas(v_active_meas),
    .locked(locked), .mode_error(mode_error)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef enum int {K_ACT, K_PX, K_LY, K_LS, K_FS, K_LOCK, K_MERR,
                    K_HT, K_HA, K_VT, K_VA, K_LINES} kind_e;
  typedef struct {
    int unsigned due;
    kind_e       kind;
    int          exp;
  } exp_t;

  exp_t        sb[$];
  int          checks    = 0;
  int          errors    = 0;
  int          lines_cnt = 0;
  bit          px_on     = 1'b0;
  int unsigned cyc       = 0;

  always @(posedge pixel_clock) cyc <= cyc + 1;

  function automatic logic [31:0] obs_of(kind_e k);
    case (k)
      K_ACT:   return 32'(active);
      K_PX:    return 32'(pixel_x);
      K_LY:    return 32'(line_y);
      K_LS:    return 32'(line_start);
      K_FS:    return 32'(frame_start);
      K_LOCK:  return 32'(locked);
      K_MERR:  return 32'(mode_error);
      K_HT:    return 32'(h_total_meas);
      K_HA:    return 32'(h_active_meas);
      K_VT:    return 32'(v_total_meas);
      K_VA:    return 32'(v_active_meas);
      default: return 32'(lines_cnt);
    endcase
  endfunction

  task automatic check(input kind_e k, input int exp);
    logic [31:0] o;
    o = obs_of(k);
    checks++;
    assert (o === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", k.name(), o, exp);
    end
  endtask

  task automatic push(input kind_e k, input int exp);
    exp_t e;
    e.due  = cyc + 32'd2;
    e.kind = k;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Scoreboard drain on the falling edge, plus line_start pulse counting
  always @(negedge pixel_clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.kind == K_LINES) begin
        if (e.exp >= 0) check(K_LINES, e.exp);
        lines_cnt = 0;
      end else begin
        check(e.kind, e.exp);
      end
    end
    if (line_start === 1'b1) lines_cnt++;
  end

  task automatic drive(input bit h, input bit v, input bit b);
    @(posedge pixel_clock);
    #1;
    h_synch_in = h;
    v_synch_in = v;
    blank_in   = b;
  endtask

  task automatic check_all_zero();
    check(K_ACT, 0);  check(K_PX, 0);   check(K_LY, 0);  check(K_LS, 0);
    check(K_FS, 0);   check(K_LOCK, 0); check(K_MERR, 0);
    check(K_HT, 0);   check(K_HA, 0);   check(K_VT, 0);  check(K_VA, 0);
  endtask

  // One full frame; v_synch high on lines va+1 and va+2, h_synch 4 cycles after front porch
  task automatic run_frame(input int ht, input int ha, input int vt, input int va,
                           input int exp_lock, input bit chk_meas);
    bit b, h, v;
    for (int y = 0; y < vt; y++) begin
      for (int x = 0; x < ht; x++) begin
        b = (x >= ha) || (y >= va);
        h = (x >= ha + 2) && (x < ha + 6);
        v = (y == va + 1) || (y == va + 2);
        drive(h, v, b);
        if (!b && px_on) begin
          if (x == 0) begin
            push(K_ACT, 1); push(K_PX, 0); push(K_LY, y);
            push(K_LS, 1);  push(K_FS, (y == 0) ? 1 : 0);
          end
          if (x == ha - 1) begin
            push(K_ACT, 1); push(K_PX, ha - 1); push(K_LY, y); push(K_LS, 0);
          end
        end
        if (y == va + 1 && x == 0) begin
          push(K_LOCK, exp_lock);
          push(K_MERR, (exp_lock != 0 && MERR_EN != 0) ? 1 : 0);
          if (chk_meas) begin
            push(K_HT, ht); push(K_HA, ha); push(K_VT, vt); push(K_VA, va);
          end
          push(K_LINES, px_on ? va : -1);
          px_on = 1'b1;
        end
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    h_synch_in = 1'b0;
    v_synch_in = 1'b0;
    blank_in   = 1'b1;
    repeat (3) @(posedge pixel_clock);
    @(negedge pixel_clock);
    check_all_zero();
    drive(1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    // Acquire and lock on the third v_synch rise
    run_frame(40, 32, 12, 8, 0, 1'b0);
    run_frame(40, 32, 12, 8, 0, 1'b1);
    run_frame(40, 32, 12, 8, 1, 1'b1);
    run_frame(40, 32, 12, 8, 1, 1'b1);

    // Horizontal total shrinks by one: lock drops, then recovers
    run_frame(39, 32, 12, 8, 0, 1'b1);
    run_frame(39, 32, 12, 8, 1, 1'b1);

    // Loss of h_synch: timeout to acquire with measurements held
    px_on = 1'b0;
    for (int i = 0; i < 2100; i++) drive(1'b0, 1'b0, 1'b1);
    push(K_LOCK, 0); push(K_ACT, 0);
    push(K_HT, 39);  push(K_HA, 32); push(K_VT, 12); push(K_VA, 8);
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    run_frame(40, 32, 12, 8, 0, 1'b0);
    run_frame(40, 32, 12, 8, 0, 1'b1);
    run_frame(40, 32, 12, 8, 1, 1'b1);

    // Reset in the middle of an active line
    for (int x = 0; x < 20; x++) drive(1'b0, 1'b0, 1'b0);
    @(negedge pixel_clock);
    check(K_ACT, 1); check(K_PX, 17); check(K_LY, 0); check(K_LOCK, 1);
    reset    = 1'b1;
    blank_in = 1'b1;
    #1;
    check_all_zero();
    px_on = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    run_frame(40, 32, 12, 8, 0, 1'b0);
    run_frame(40, 32, 12, 8, 0, 1'b1);
    run_frame(40, 32, 12, 8, 1, 1'b1);

    // Switch to a different raster while locked
    run_frame(50, 40, 14, 10, 0, 1'b0);
    run_frame(50, 40, 14, 10, 1, 1'b1);
    run_frame(50, 40, 14, 10, 1, 1'b1);

    repeat (5) drive(1'b0, 1'b0, 1'b1);
    @(negedge pixel_clock);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/svga_timing_receiver.md
# svga_timing_receiver

Recovers raster position and measures video timing from an incoming h_synch / v_synch / blank stream of the form our SVGA timing generator drives (active-high sync pulses, active-high composite blank). It regenerates pixel and line coordinates, reports measured geometry, and declares lock once the geometry is stable. It sits at the sink end of the video path, for capture, loopback checking and overlay logic that only sees sync signals.

## Interface
- LOCK_FRAMES, 2: consecutive identical frame measurements required to assert locked (1..15)
- H_W, 11: width of horizontal counters and measurements
- V_W, 10: width of vertical counters and measurements
- pixel_clock  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- h_synch_in  in  1  horizontal sync, high during pulse
- v_synch_in  in  1  vertical sync, high during pulse, edges aligned to line boundaries
- blank_in  in  1  composite blank, high outside active video
- active  out  1  recovered active-video flag
- pixel_x  out  H_W  pixel index within active line
- line_y  out  V_W  active line index within frame
- line_start  out  1  one-cycle pulse on first active pixel of each line
- frame_start  out  1  one-cycle pulse on first active pixel of line 0
- h_total_meas  out  H_W  cycles between h_synch rising edges
- h_active_meas  out  H_W  blank-low cycles per active line
- v_total_meas  out  V_W  h_synch rising edges per frame
- v_active_meas  out  V_W  blank-low runs per frame
- locked  out  1  geometry stable
- mode_error  out  1  geometry differs from shared expected constants

## Operation
- Inputs captured in two register stages (d1, d2); rise = d1 & ~d2, fall = ~d1 & d2, per signal.
- blank fall: pixel_x <= 0, active <= 1, line_start pulse; line_y <= 0 if first blank fall since last v_synch rise (frame_start pulse), else line_y + 1.
- While active: pixel_x increments each cycle, saturating at all-ones. blank rise: active <= 0; pixel_x and line_y hold.
- Running counters: hcnt (reset on h_synch rise), hact (blank-low cycles), vcnt (h_synch rises), vact (blank falls); vcnt/vact cleared on v_synch rise.
- On each v_synch rise, the just-finished frame's values form the candidate set {hcnt, hact of last active line, vcnt, vact}.
- FSM: ACQUIRE: wait for v_synch rise -> MEASURE (counters cleared, nothing latched).
- MEASURE: at next v_synch rise latch candidate into *_meas, match_cnt <= 1 -> CONFIRM.
- CONFIRM: at each v_synch rise compare candidate vs *_meas; equal -> match_cnt+1, reaching LOCK_FRAMES -> LOCKED, locked <= 1; unequal -> relatch *_meas, match_cnt <= 1.
- LOCKED: unequal candidate -> locked <= 0, relatch, match_cnt <= 1 -> CONFIRM.
- Timeout: hcnt reaching all-ones (no h_synch rise) from any state -> ACQUIRE, locked <= 0, active <= 0; *_meas hold.
- Reset (any time): all outputs 0, FSM ACQUIRE, match_cnt 0.

## Timing
- active, pixel_x, line_y, line_start, frame_start lag blank_in by exactly 2 cycles: blank_in first low in cycle k -> active=1, pixel_x=0 in cycle k+2. Consumers delay pixel data by 2.
- locked, *_meas, mode_error update 2 cycles after the v_synch_in rising sample; earliest lock is the third v_synch rise after reset.
- Simultaneous h_synch and v_synch rise: the h_synch rise counts in the finishing frame's vcnt before clearing.

## Configuration
- SVGA_TIMING_CHECK_EN defined: when locked, mode_error <= 1 if any *_meas differs from shared expected constants (H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE), else 0; cleared when lock drops.
- Undefined: mode_error tied 0, comparators absent.

## Structure
- Shared package: expected SVGA geometry constants, FSM state encoding, H_W/V_W defaults.
- One sub-module: svga_edge_detect (two-stage capture plus rise/fall pulses), instantiated per input.

## Test plan
- Reset, drive 800x600 stream (H 1056/800, V 628/600), LOCK_FRAMES=2 -> locked=1 after third v_synch rise; meas = 1056, 800, 628, 600.
- Locked 800x600 -> first active pixel: frame_start=1, pixel_x=0, line_y=0; last: pixel_x=799, line_y=599; 600 line_start pulses per frame.
- Switch to H total 1055 mid-stream -> locked=0 at next frame end, h_total_meas=1055, relock two frames later.
- Hold h_synch_in low 2100 cycles -> locked=0, active=0, FSM ACQUIRE, *_meas unchanged.
- Assert reset mid-line -> all outputs 0 immediately; relock needs three new v_synch rises.
- With SVGA_TIMING_CHECK_EN, 640x480 stream (800/640, 525/480) vs 800x600 constants -> locked=1, mode_error=1; without macro mode_error=0.
